tensor_stream_reader: RTL and testbench
=======================================

# tensor_stream_reader

Parametrised streaming reader that walks a tensor stored in `tensor_ram` (one 32-bit word = four int8 channels) in raster order and presents it as a ready/valid stream to `sliding_window` and later consumers. It replaces the fixed-geometry `pixel_reader` with four additions:

- image size, channel-chunk count and base address set at run time;
- optional one-pixel zero padding;
- downstream backpressure;
- first/last/done framing.

## Interface
Parameters:
- `MAX_W`, default 96: maximum image width in pixels.
- `MAX_H`, default 96: maximum image height in pixels.
- `MAX_CC`, default 16: maximum channel chunks per pixel (4 channels per chunk).
- `D_WIDTH`, default 32: RAM word width.
- `ADDR_W`, default `$clog2(MAX_W*MAX_H*MAX_CC)`: RAM address width.

Ports:
- `clk`  in  1  clock, all logic on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `img_w`  in  `$clog2(MAX_W+1)`  width, latched on start.
- `img_h`  in  `$clog2(MAX_H+1)`  height, latched on start.
- `c_chunks`  in  `$clog2(MAX_CC+1)`  words per pixel, latched on start.
- `base_addr`  in  ADDR_W  address of pixel (0,0) chunk 0, latched on start.
- `pad_en`  in  1  emit one-pixel zero border, latched on start.
- `addr_r`  out  ADDR_W  RAM read address. The RAM has one-cycle registered read latency.
- `ram_dout`  in  D_WIDTH  RAM read data.
- `out_data`  out  D_WIDTH  stream word.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts the word.
- `out_first`  out  1  word is the first element of the frame.
- `out_last`  out  1  word is the final element of the frame.
- `busy`  out  1  high from the cycle after start is accepted until done.
- `done`  out  1  one-cycle pulse after the final handshake (or for an empty frame).

## Operation
- States are IDLE, RUN and DRAIN.
- **IDLE.** If `start` is high, latch the configuration and go to RUN. A zero `img_w`, `img_h` or `c_chunks` is an empty frame: pulse `done` the next cycle and stay in IDLE.
- **Iteration order.** The iteration grid is `Wg×Hg`, where `Wg = img_w + 2·pad_en` and `Hg = img_h + 2·pad_en`. Loop nesting is row gy (outer), then column gx, then chunk c (inner).
- **Element type.** An element is a pad element if `pad_en` is set and it lies on the grid border (gy=0, gy=Hg−1, gx=0 or gx=Wg−1). Every other element is a data element.
- **Address counter.** `rd_ptr` starts at `base_addr` and increments by 1 only on data-element issue. Data is contiguous: the address equals `base + ((y·img_w + x)·c_chunks + c)`.
- **Issue pipeline.** Each issued element travels through one pipeline stage with a pad flag. At capture, pad elements push 0 and data elements push `ram_dout` into a 2-entry output FIFO.
- **Issue rule (RUN).** Issue when `fifo_count + inflight − (out_valid & out_ready) ≤ 1`. With this rule the FIFO never overflows and throughput is 1 element/cycle when `out_ready` is held high.
- **RUN to DRAIN.** Move to DRAIN after issuing element `Wg·Hg·c_chunks − 1`.
- **DRAIN to IDLE.** When the last element handshakes, pulse `done`, clear `busy` and return to IDLE.
- **Framing.** `out_first` and `out_last` are stored in the FIFO alongside the data and are meaningful only while `out_valid` is high.
- **Start while busy.** `start` asserted while not in IDLE is ignored.
- **Stalls.** `out_data` and the framing bits are held stable while `out_valid & !out_ready`.
- **addr_r.** `addr_r` equals `rd_ptr` in all states. Reads issued in non-issue cycles are harmless and discarded.

## Timing
- **Reset values.** `out_valid`, `out_first`, `out_last`, `busy` and `done` are 0. `out_data` is 0, `addr_r` is 0, the FIFO is empty and the state is IDLE.
- **Latency** (`start` high in cycle 0, `out_ready` high):
  - cycle 1: `busy`=1, first address on `addr_r`;
  - cycle 2: `ram_dout` valid;
  - cycle 3: `out_valid`=1 with element 0.
- **Done timing.** With N elements and no stalls, the last handshake is in cycle N+2 and `done` pulses in cycle N+3, with `busy`=0 in the same cycle.
- **Pad element timing.** Pad elements take exactly the same 2-cycle path as data elements, so latency is uniform.
- **Reset mid-frame.** Reset returns the block to IDLE, drops in-flight and queued elements and produces no `done`.
- **Start with reset.** `start` in the same cycle as `reset` is ignored.
- **Back-to-back frames.** `start` may be asserted in the same cycle that `done` pulses. It is accepted because the state is IDLE in that cycle.

## Test plan
- **Basic frame.** `img_w`=4, `img_h`=3, `c_chunks`=1, `base_addr`=10, `pad_en`=0, `out_ready`=1, RAM[a]=a. Expect 12 words, values 10..21 in order. Expect `out_valid` first in cycle 3, `out_first` on 10, `out_last` on 21 and `done` in cycle 15.
- **Zero padding.** `img_w`=`img_h`=2, `c_chunks`=1, `pad_en`=1, base 0, RAM[a]=a+1. Expect 16 words: 0,0,0,0, 0,1,2,0, 0,3,4,0, 0,0,0,0. Exactly 4 RAM advances.
- **Channel chunks.** `img_w`=2, `img_h`=1, `c_chunks`=3, base 100. Expect words 100..105, i.e. pixel 0 chunks 0–2 then pixel 1 chunks 0–2.
- **Backpressure.** Basic frame with `out_ready` pseudo-random (50%) plus an 8-cycle hold-low. Expect identical ordered sequence, no drops or duplicates, and output held stable while stalled. `done` follows the last handshake by 1 cycle.
- **Empty frame and ignored start.** `img_w`=0 gives a `done` pulse in cycle 1 and no `out_valid`. Separately, `start` pulsed mid-frame is ignored: the sequence is unchanged and there is one `done`.
- **Reset mid-frame.** Assert `reset` after the 5th handshake. Next cycle: `out_valid`=0, `busy`=0, no `done`. A new frame then runs correctly from its first element.

Source files
------------

// File: rtl/tensor_stream_reader.sv
// Raster-order tensor reader: walks tensor_ram (one word = 4 int8 channels) row/column/chunk
// and streams the words with optional one-pixel zero border, backpressure and first/last framing.
module tensor_stream_reader #(
    parameter int MAX_W   = 96,
    parameter int MAX_H   = 96,
    parameter int MAX_CC  = 16,
    parameter int D_WIDTH = 32,
    parameter int ADDR_W  = $clog2(MAX_W * MAX_H * MAX_CC)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic [$clog2(MAX_W+1)-1:0]  img_w,
    input  logic [$clog2(MAX_H+1)-1:0]  img_h,
    input  logic [$clog2(MAX_CC+1)-1:0] c_chunks,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic                        pad_en,
    output logic [ADDR_W-1:0]           addr_r,
    input  logic [D_WIDTH-1:0]          ram_dout,
    output logic [D_WIDTH-1:0]          out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_first,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done,
    output logic [1:0]                  dbg_state_o
);
    localparam int WW = $clog2(MAX_W + 1);
    localparam int HW = $clog2(MAX_H + 1);
    localparam int CW = $clog2(MAX_CC + 1);
    localparam int GW = $clog2(MAX_W + 3);
    localparam int GH = $clog2(MAX_H + 3);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t              state_q;
    logic [WW-1:0]       w_q;
    logic [HW-1:0]       h_q;
    logic [CW-1:0]       cc_q;
    logic                pad_q;
    logic [GW-1:0]       gx_q;
    logic [GH-1:0]       gy_q;
    logic [CW-1:0]       c_q;
    logic [ADDR_W-1:0]   rd_ptr_q;
    logic                infl_q;
    logic                infl_pad_q;
    logic                infl_first_q;
    logic                infl_last_q;
    logic [D_WIDTH-1:0]  fifo_data_q [2];
    logic                fifo_first_q [2];
    logic                fifo_last_q [2];
    logic                rd_idx_q;
    logic                wr_idx_q;
    logic [1:0]          count_q;
    logic                busy_q;
    logic                done_q;

    logic [GW-1:0]       grid_w;
    logic [GH-1:0]       grid_h;
    logic                pop;
    logic [2:0]          occ;
    logic                issue;
    logic                last_col;
    logic                last_row;
    logic                last_chunk;
    logic                is_pad;
    logic                is_first;
    logic                is_last;
    logic                cfg_empty;
    logic [D_WIDTH-1:0]  push_data;

    assign grid_w = GW'(w_q) + (pad_q ? GW'(2) : GW'(0));
    assign grid_h = GH'(h_q) + (pad_q ? GH'(2) : GH'(0));

    always_comb begin
        pop        = (count_q != 2'd0) && out_ready;
        // Occupancy after this edge, before counting a newly issued element.
        occ        = {1'b0, count_q} + {2'b0, infl_q} - {2'b0, pop};
        issue      = (state_q == RUN) && (occ <= 3'd1);
        last_col   = (gx_q == grid_w - GW'(1));
        last_row   = (gy_q == grid_h - GH'(1));
        last_chunk = (c_q == cc_q - CW'(1));
        is_pad     = pad_q && ((gx_q == '0) || (gy_q == '0) || last_col || last_row);
        is_first   = (gx_q == '0) && (gy_q == '0) && (c_q == '0);
        is_last    = last_col && last_row && last_chunk;
        cfg_empty  = (img_w == '0) || (img_h == '0) || (c_chunks == '0);
        push_data  = infl_pad_q ? '0 : ram_dout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            w_q          <= '0;
            h_q          <= '0;
            cc_q         <= '0;
            pad_q        <= 1'b0;
            gx_q         <= '0;
            gy_q         <= '0;
            c_q          <= '0;
            rd_ptr_q     <= '0;
            infl_q       <= 1'b0;
            infl_pad_q   <= 1'b0;
            infl_first_q <= 1'b0;
            infl_last_q  <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                fifo_data_q[i]  <= '0;
                fifo_first_q[i] <= 1'b0;
                fifo_last_q[i]  <= 1'b0;
            end
            rd_idx_q     <= 1'b0;
            wr_idx_q     <= 1'b0;
            count_q      <= 2'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q       <= 1'b0;
            infl_q       <= issue;
            infl_pad_q   <= is_pad;
            infl_first_q <= is_first;
            infl_last_q  <= is_last;

            // The RAM word for the element issued last cycle is on ram_dout now.
            if (infl_q) begin
                fifo_data_q[wr_idx_q]  <= push_data;
                fifo_first_q[wr_idx_q] <= infl_first_q;
                fifo_last_q[wr_idx_q]  <= infl_last_q;
                wr_idx_q               <= ~wr_idx_q;
            end
            if (pop) begin
                rd_idx_q <= ~rd_idx_q;
            end
            count_q <= count_q + {1'b0, infl_q} - {1'b0, pop};

            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (cfg_empty) begin
                            done_q <= 1'b1;
                        end else begin
                            w_q      <= img_w;
                            h_q      <= img_h;
                            cc_q     <= c_chunks;
                            pad_q    <= pad_en;
                            rd_ptr_q <= base_addr;
                            gx_q     <= '0;
                            gy_q     <= '0;
                            c_q      <= '0;
                            busy_q   <= 1'b1;
                            state_q  <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (!is_pad) begin
                            rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
                        end
                        if (last_chunk) begin
                            c_q <= '0;
                            if (last_col) begin
                                gx_q <= '0;
                                gy_q <= gy_q + GH'(1);
                            end else begin
                                gx_q <= gx_q + GW'(1);
                            end
                        end else begin
                            c_q <= c_q + CW'(1);
                        end
                        if (is_last) begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && fifo_last_q[rd_idx_q]) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign addr_r      = rd_ptr_q;
    assign out_valid   = (count_q != 2'd0);
    assign out_data    = fifo_data_q[rd_idx_q];
    assign out_first   = fifo_first_q[rd_idx_q];
    assign out_last    = fifo_last_q[rd_idx_q];
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_tensor_stream_reader.sv
// Bench for tensor_stream_reader: a registered-read RAM model, a frame-level expected queue
// built from the raster/padding rules, and a per-cycle compare process on the falling edge.
module tb_tensor_stream_reader;
    localparam int ADDR_W = $clog2(96 * 96 * 16);

    logic              clk;
    logic              reset;
    logic              start;
    logic [6:0]        img_w;
    logic [6:0]        img_h;
    logic [4:0]        c_chunks;
    logic [ADDR_W-1:0] base_addr;
    logic              pad_en;
    logic [ADDR_W-1:0] addr_r;
    logic [31:0]       ram_dout;
    logic [31:0]       out_data;
    logic              out_valid;
    logic              out_ready;
    logic              out_first;
    logic              out_last;
    logic              busy;
    logic              done;
    logic [1:0]        dbg_state;

    tensor_stream_reader dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .img_w       (img_w),
        .img_h       (img_h),
        .c_chunks    (c_chunks),
        .base_addr   (base_addr),
        .pad_en      (pad_en),
        .addr_r      (addr_r),
        .ram_dout    (ram_dout),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_first   (out_first),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int ram_mode = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t", name, act, act, exp, exp, $time);
        end
    endtask

    function automatic logic [31:0] ram_fn(input logic [ADDR_W-1:0] a);
        logic [31:0] x;
        x = 32'(a);
        case (ram_mode)
            0:       return x;
            1:       return x + 32'd1;
            default: return (x * 32'h9E3779B1) ^ 32'h5A5A_0000;
        endcase
    endfunction

    always @(posedge clk) ram_dout <= ram_fn(addr_r);

    // ---------------- model + scoreboard ----------------
    logic [33:0]       exp_q[$];   // {first, last, data}
    logic [31:0]       rx_q[$];
    logic [33:0]       e;
    bit                chk_en = 0;
    bit                m_idle = 1;
    bit                done_exp = 0;
    bit                stall_prev = 0;
    bit                hs;
    bit                last_hs;
    logic [31:0]       held_d;
    logic [1:0]        held_fl;
    logic [ADDR_W-1:0] prev_addr = '0;
    int                cyc = 0;
    int                start_cyc = 0;
    int                first_rel = -1;
    int                done_rel = -1;
    int                done_cnt = 0;
    int                frame_hs = 0;
    int                adv_cnt = 0;

    task automatic build_frame(input int w, input int h, input int cc, input int base, input int pad);
        int wg, hg, n, k, addr;
        bit is_pad;
        logic [31:0] d;
        wg = w + 2 * pad;
        hg = h + 2 * pad;
        n  = wg * hg * cc;
        k  = 0;
        for (int gy = 0; gy < hg; gy++)
            for (int gx = 0; gx < wg; gx++)
                for (int c = 0; c < cc; c++) begin
                    is_pad = (pad != 0) && (gy == 0 || gy == hg - 1 || gx == 0 || gx == wg - 1);
                    addr   = base + (((gy - pad) * w + (gx - pad)) * cc + c);
                    d      = is_pad ? 32'd0 : ram_fn(ADDR_W'(addr));
                    exp_q.push_back({k == 0, k == n - 1, d});
                    k++;
                end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cyc++;
            chk("done", 32'(done), 32'(done_exp));
            chk("busy", 32'(busy), 32'(!m_idle));
            if (stall_prev) begin
                chk("stall_valid", 32'(out_valid), 32'd1);
                chk("stall_data", out_data, held_d);
                chk("stall_framing", 32'({out_first, out_last}), 32'(held_fl));
            end
            if (out_valid && first_rel < 0) first_rel = cyc - start_cyc;
            if (done) begin
                done_cnt++;
                done_rel = cyc - start_cyc;
            end
            hs = out_valid && out_ready;
            last_hs = 0;
            if (hs) begin
                if (exp_q.size() == 0) begin
                    chk("extra_word", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("data", out_data, e[31:0]);
                    chk("first", 32'(out_first), 32'(e[33]));
                    chk("last", 32'(out_last), 32'(e[32]));
                    last_hs = e[32];
                    rx_q.push_back(out_data);
                    frame_hs++;
                end
            end
            stall_prev = out_valid && !out_ready;
            held_d     = out_data;
            held_fl    = {out_first, out_last};
            if (addr_r == prev_addr + ADDR_W'(1)) adv_cnt++;
            prev_addr = addr_r;

            if (reset) begin
                exp_q.delete();
                m_idle     = 1;
                done_exp   = 0;
                stall_prev = 0;
            end else begin
                done_exp = 0;
                if (m_idle && start) begin
                    start_cyc = cyc;
                    first_rel = -1;
                    if (img_w == 0 || img_h == 0 || c_chunks == 0) begin
                        done_exp = 1;
                    end else begin
                        build_frame(int'(img_w), int'(img_h), int'(c_chunks), int'(base_addr), int'(pad_en));
                        m_idle = 0;
                    end
                end else if (last_hs) begin
                    m_idle   = 1;
                    done_exp = 1;
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic pick_ready(input int mode, input int k);
        case (mode)
            0:       return 1'b1;
            1:       return 1'($urandom_range(0, 1));
            default: return (k >= 5 && k < 13) ? 1'b0 : 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic set_cfg(input int w, input int h, input int cc, input int base, input int pad);
        img_w     = 7'(w);
        img_h     = 7'(h);
        c_chunks  = 5'(cc);
        base_addr = ADDR_W'(base);
        pad_en    = 1'(pad);
    endtask

    task automatic start_frame(input int w, input int h, input int cc, input int base, input int pad);
        @(posedge clk); #1;
        set_cfg(w, h, cc, base, pad);
        rx_q.delete();
        frame_hs = 0;
        adv_cnt  = 0;
        start    = 1'b1;
    endtask

    task automatic wait_done(input int mode, input int budget, input bit hold_start, input string what);
        int d0;
        int k;
        d0 = done_cnt;
        k  = 0;
        while (done_cnt == d0 && k < budget) begin
            @(posedge clk); #1;
            out_ready = pick_ready(mode, k);
            if (!hold_start) start = 1'b0;
            k++;
        end
        start = 1'b0;
        if (done_cnt == d0) begin
            total++;
            bad++;
            $display("FAIL timeout_%s: done count stayed %0d, required %0d", what, done_cnt, d0 + 1);
        end
    endtask

    task automatic run_cycles(input int n, input int mode);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            out_ready = pick_ready(mode, k);
            start     = 1'b0;
        end
    endtask

    task automatic chk_rx_seq(input string name, input int first_val, input int n);
        chk({name, "_count"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n; i++)
            chk(name, (i < rx_q.size()) ? rx_q[i] : 32'hDEAD_BEEF, 32'(first_val + i));
    endtask

    // ---------------- stimulus ----------------
    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pad_exp [16];
        int w, h, cc, base, pad, wk;

        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        set_cfg(0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_first", 32'(out_first), 32'd0);
        chk("rst_last", 32'(out_last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_data", out_data, 32'd0);
        chk("rst_addr", 32'(addr_r), 32'd0);
        chk_en = 1;

        // Basic frame
        ram_mode = 0;
        start_frame(4, 3, 1, 10, 0);
        wait_done(0, 200, 0, "basic");
        chk_rx_seq("basic_word", 10, 12);
        chk("basic_first_valid_cycle", 32'(first_rel), 32'd3);
        chk("basic_done_cycle", 32'(done_rel), 32'd15);

        // Zero padding
        ram_mode = 1;
        pad_exp = '{0, 0, 0, 0, 0, 1, 2, 0, 0, 3, 4, 0, 0, 0, 0, 0};
        start_frame(2, 2, 1, 0, 1);
        wait_done(0, 200, 0, "pad");
        chk("pad_count", 32'(rx_q.size()), 32'd16);
        for (int i = 0; i < 16; i++)
            chk("pad_word", (i < rx_q.size()) ? rx_q[i] : 32'hDEAD_BEEF, pad_exp[i]);
        chk("pad_ram_advances", 32'(adv_cnt), 32'd4);

        // Channel chunks
        ram_mode = 0;
        start_frame(2, 1, 3, 100, 0);
        wait_done(0, 200, 0, "chunks");
        chk_rx_seq("chunk_word", 100, 6);

        // Backpressure: random ready with an 8-cycle hold-low
        start_frame(4, 3, 1, 10, 0);
        wait_done(2, 600, 0, "backpressure");
        chk_rx_seq("bp_word", 10, 12);

        // Empty frame
        start_frame(0, 3, 1, 10, 0);
        wait_done(0, 50, 0, "empty");
        chk("empty_done_cycle", 32'(done_rel), 32'd1);
        run_cycles(4, 0);
        chk("empty_no_valid", 32'(first_rel), 32'hFFFF_FFFF);

        // Start held mid-frame is ignored, then accepted in the done cycle
        ram_mode = 2;
        start_frame(3, 2, 2, 50, 1);
        run_cycles(6, 1);
        set_cfg(2, 2, 1, 7, 0);
        start = 1'b1;
        wait_done(1, 800, 1, "b2b_first");
        wait_done(1, 800, 0, "b2b_second");

        // Reset after the 5th handshake, with a simultaneous start
        ram_mode = 0;
        start_frame(4, 3, 1, 10, 0);
        wk = 0;
        while (frame_hs < 5 && wk < 100) begin
            @(posedge clk); #1;
            out_ready = 1'b1;
            start = 1'b0;
            wk++;
        end
        chk("reached_5_handshakes", 32'(frame_hs >= 5), 32'd1);
        @(posedge clk); #1;
        reset = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk("rst_mid_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_done", 32'(done), 32'd0);
        start_frame(2, 1, 3, 100, 0);
        wait_done(0, 200, 0, "after_reset");
        chk_rx_seq("after_reset_word", 100, 6);

        // Randomised frames
        for (int f = 0; f < 8; f++) begin
            w    = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 6);
            h    = $urandom_range(1, 5);
            cc   = $urandom_range(1, 4);
            base = $urandom_range(0, 2000);
            pad  = $urandom_range(0, 1);
            ram_mode = $urandom_range(0, 2);
            start_frame(w, h, cc, base, pad);
            wait_done($urandom_range(0, 2), 4000, 0, "random");
        end

        run_cycles(5, 0);
        chk("leftover_expected", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
